// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the memory arbiter.
// slave is the arbiter's view; master is the view of the caches and RAM around it.
interface mem_arbiter_if #(
    parameter int unsigned WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache requests onto one RAM port. Data wins ties; a starvation
// counter forces an instruction grant after STARVE_LIMIT data completions.
module mem_arbiter #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0]       RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {StIdle, StServeD, StServeI} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              access, dreq;
    logic              ram_ren, ram_wen, i_wait, d_wait;
    logic [WORD_W-1:0] ram_addr, ram_store, i_load, d_load;

    assign access = (bus.ramstate == RAM_ACCESS);
    assign dreq   = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.iREN) starve_d = '0;
                if (bus.iREN && starve_q == LIMIT) state_d = StServeI;
                else if (dreq)                     state_d = StServeD;
                else if (bus.iREN)                 state_d = StServeI;
            end
            StServeD: begin
                // A withdrawn request is abandoned, not counted as a completion.
                if (!dreq) begin
                    state_d = StIdle;
                end else if (access) begin
                    state_d = StIdle;
                    if (bus.iREN && starve_q != LIMIT) starve_d = starve_q + 1'b1;
                end
            end
            StServeI: begin
                if (!bus.iREN) begin
                    state_d = StIdle;
                end else if (access) begin
                    state_d  = StIdle;
                    starve_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_wait    = 1'b1;
        i_load    = '0;
        d_wait    = 1'b1;
        d_load    = '0;
        unique case (state_q)
            StServeD: begin
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                d_wait    = ~access;
                if (access) d_load = bus.ramload;
            end
            StServeI: begin
                ram_addr = bus.iaddr;
                ram_ren  = 1'b1;
                i_wait   = ~access;
                if (access) i_load = bus.ramload;
            end
            default: ;
        endcase
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = i_wait;
    assign bus.iload    = i_load;
    assign bus.dwait    = d_wait;
    assign bus.dload    = d_load;
endmodule
